// File: rtl/dif_radix2_64p_da_ctrl_pkg.sv
// Shared definitions for the 64-point radix-2 DIF reorder controller:
// FSM states, frame geometry and the 6-bit bit-reverse helper.
package dif_radix2_64p_da_ctrl_pkg;

    localparam int FRAME_LEN = 64;
    localparam int CNT_WIDTH = 6;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    // Mirror the index bits; maps a DIF output position to its natural-order sample.
    function automatic logic [CNT_WIDTH-1:0] bitrev6(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        for (int i = 0; i < CNT_WIDTH; i++) begin
            r[i] = v[CNT_WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/dif_radix2_64p_da_ctrl.sv
// Register-file write/read address controller for a 64-point DIF reorder buffer.
// Define DA_CTRL_BITREV_EN for bit-reversed readout; otherwise frames pass through in order.
module dif_radix2_64p_da_ctrl
    import dif_radix2_64p_da_ctrl_pkg::*;
#(
    parameter int RF_DEPTH   = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [RF_DEPTH-1:0]   wen_ctrl,
    output logic [ADDR_WIDTH-1:0] waddr_ctrl,
    output logic [RF_DEPTH-1:0]   ren_ctrl,
    output logic [ADDR_WIDTH-1:0] raddr_ctrl,
    output logic                  out_valid,
    output logic                  out_last,
    output logic                  busy
);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0] src;

    // The RF has one cycle of read latency, so valid/last are the read issue delayed once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out_valid <= (state == READ);
            out_last  <= (state == READ) && (cnt == LAST_CNT);
        end
    end

`ifdef DA_CTRL_BITREV_EN
    assign src = bitrev6(cnt);
`else
    assign src = cnt;
`endif

    // Upper counter bits pick the bank, lower bits the word; IDLE holds cnt at 0,
    // so it shares the WRITE path and accepts sample 0 directly.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        in_ready   = 1'b0;
        wen_ctrl   = '0;
        waddr_ctrl = '0;
        ren_ctrl   = '0;
        raddr_ctrl = '0;
        case (state)
            IDLE, WRITE: begin
                in_ready   = 1'b1;
                waddr_ctrl = cnt[ADDR_WIDTH-1:0];
                if (in_valid) begin
                    wen_ctrl[cnt[CNT_WIDTH-1 -: ADDR_WIDTH]] = 1'b1;
                    if (cnt == LAST_CNT) begin
                        cnt_nxt   = '0;
                        state_nxt = READ;
                    end else begin
                        cnt_nxt   = cnt + CNT_WIDTH'(1);
                        state_nxt = WRITE;
                    end
                end
            end
            READ: begin
                ren_ctrl[src[CNT_WIDTH-1 -: ADDR_WIDTH]] = 1'b1;
                raddr_ctrl = src[ADDR_WIDTH-1:0];
                if (cnt == LAST_CNT) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt   = cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE) || out_valid;

endmodule

// File: tb/tb_dif_radix2_64p_da_ctrl.sv
// Self-checking bench for dif_radix2_64p_da_ctrl: a behavioural register file
// holds sample data, and a frame-level model predicts controls and output order.
module tb_dif_radix2_64p_da_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] din = '0;
    logic       in_ready;
    logic [7:0] wen_ctrl;
    logic [2:0] waddr_ctrl;
    logic [7:0] ren_ctrl;
    logic [2:0] raddr_ctrl;
    logic       out_valid;
    logic       out_last;
    logic       busy;

    int totalChecks = 0;
    int badChecks = 0;

    dif_radix2_64p_da_ctrl #(.RF_DEPTH(8), .ADDR_WIDTH(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .wen_ctrl(wen_ctrl),
        .waddr_ctrl(waddr_ctrl),
        .ren_ctrl(ren_ctrl),
        .raddr_ctrl(raddr_ctrl),
        .out_valid(out_valid),
        .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural RF: eight banks of eight words, one-cycle read latency.
    logic [7:0] rfMem [64];
    logic [7:0] rfDout = '0;

    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (wen_ctrl[b]) rfMem[b*8 + int'(waddr_ctrl)] <= din;
            if (ren_ctrl[b]) rfDout <= rfMem[b*8 + int'(raddr_ctrl)];
        end
    end

    // Frame-level model: samples accepted so far, reads issued, pending output.
    int         mAcc = 0;
    int         mRd = 0;
    logic [7:0] mFrame [64];
    bit         mPendValid = 0;
    bit         mPendLast = 0;
    logic [7:0] mPendData = '0;

    function automatic int expSrc(input int r);
`ifdef DA_CTRL_BITREV_EN
        int s = 0;
        int v = r;
        for (int i = 0; i < 6; i++) begin
            s = s * 2 + (v % 2);
            v = v / 2;
        end
        return s;
`else
        return r;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, check all outputs against the model, advance the model.
    task automatic applyStimulus(input bit v, input logic [7:0] d);
        bit reading;
        bit xfer;
        int s;
        @(negedge clk);
        in_valid = v;
        din = d;
        #1;
        reading = (mAcc == 64);
        xfer = v && !reading;
        s = expSrc(mRd);
        checkOutput("in_ready", 32'(in_ready), 32'(!reading));
        checkOutput("wen_ctrl", 32'(wen_ctrl), xfer ? 32'(1 << (mAcc / 8)) : 32'd0);
        if (xfer) checkOutput("waddr_ctrl", 32'(waddr_ctrl), 32'(mAcc % 8));
        checkOutput("ren_ctrl", 32'(ren_ctrl), reading ? 32'(1 << (s / 8)) : 32'd0);
        checkOutput("raddr_ctrl", 32'(raddr_ctrl), reading ? 32'(s % 8) : 32'd0);
        checkOutput("out_valid", 32'(out_valid), 32'(mPendValid));
        checkOutput("out_last", 32'(out_last), 32'(mPendLast));
        if (mPendValid) checkOutput("out_data", 32'(rfDout), 32'(mPendData));
        checkOutput("busy", 32'(busy), 32'((mAcc > 0) || mPendValid));
        mPendValid = reading;
        mPendLast = 0;
        if (reading) begin
            mPendData = mFrame[s];
            mPendLast = (mRd == 63);
            mRd++;
            if (mRd == 64) begin
                mRd = 0;
                mAcc = 0;
            end
        end
        if (xfer) begin
            mFrame[mAcc] = d;
            mAcc++;
        end
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_wen", 32'(wen_ctrl), 32'd0);
        checkOutput("rst_ren", 32'(ren_ctrl), 32'd0);
        checkOutput("rst_waddr", 32'(waddr_ctrl), 32'd0);
        checkOutput("rst_raddr", 32'(raddr_ctrl), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        mAcc = 0;
        mRd = 0;
        mPendValid = 0;
        mPendLast = 0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting");
        doReset(4);

        // Continuous frame with values 0..63, then drain through READ.
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(i));
        for (int i = 0; i < 66; i++) applyStimulus(1'b0, 8'hEE);

        // in_valid held high through READ: back-to-back frames of random data.
        for (int i = 0; i < 64 * 4 + 2; i++) applyStimulus(1'b1, 8'($urandom));
        for (int i = 0; i < 140; i++) applyStimulus(1'b0, 8'hEE);

        // Gapped input: valid every other cycle.
        for (int i = 0; i < 128; i++) applyStimulus(i % 2 == 0, 8'($urandom));
        for (int i = 0; i < 70; i++) applyStimulus(1'b0, 8'hEE);

        // Random valid pattern over several frames.
        for (int i = 0; i < 600; i++) applyStimulus($urandom_range(0, 3) != 0, 8'($urandom));
        for (int i = 0; i < 140; i++) applyStimulus(1'b0, 8'hEE);

        // Reset at write sample 40 abandons the frame; next frame restarts at bank 0 addr 0.
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'($urandom));
        doReset(1);
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'($urandom));
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 8'hEE);

        // Reset in the middle of READ: no output may follow.
        doReset(2);
        for (int i = 0; i < 70; i++) applyStimulus(1'b0, 8'hEE);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/dif_radix2_64p_da_ctrl.md
DIF_RADIX2_64P_DA_CTRL -- requirements
Module: dif_radix2_64p_da_ctrl

Interface
REQ-001 Parameter RF_DEPTH, default 8: number of register-file banks and words per bank; frame length is RF_DEPTH*RF_DEPTH (64).
REQ-002 Parameter ADDR_WIDTH, default 3: log2(RF_DEPTH); bank and word address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream sample present on the RF din_real/din_imag bus this cycle.
REQ-006 in_ready  output  1  controller accepts a sample this cycle; transfer when in_valid && in_ready.
REQ-007 wen_ctrl  output  RF_DEPTH  one-hot RF bank write enable.
REQ-008 waddr_ctrl  output  ADDR_WIDTH  RF word write address.
REQ-009 ren_ctrl  output  RF_DEPTH  one-hot RF bank read enable.
REQ-010 raddr_ctrl  output  ADDR_WIDTH  RF word read address.
REQ-011 out_valid  output  1  RF dout_real/dout_imag holds a valid reordered sample.
REQ-012 out_last  output  1  qualifies out_valid for sample 63 of the frame.
REQ-013 busy  output  1  high in WRITE or READ, or while out_valid is high.

Function
REQ-014 FSM states IDLE, WRITE, READ; 6-bit sample counter cnt.
REQ-015 IDLE: in_ready=1; on first transfer write sample 0, cnt<=1, go WRITE; otherwise stay.
REQ-016 Write mapping, combinational from cnt and transfer: wen_ctrl = one-hot(cnt[5:3]) gated by in_valid&&in_ready, waddr_ctrl = cnt[2:0]; wen_ctrl=0 when no transfer.
REQ-017 WRITE: in_ready=1; each transfer increments cnt; in_valid low holds cnt and wen_ctrl=0 (gaps allowed, no timeout).
REQ-018 Transfer at cnt=63 -> cnt<=0, go READ next cycle; in_ready=0 from that cycle.
REQ-019 READ: one read per cycle, no stalls, 64 consecutive cycles; read index r=cnt; source s = bitrev6(r) (see REQ-027); ren_ctrl=one-hot(s[5:3]), raddr_ctrl=s[2:0].
REQ-020 READ at cnt=63 -> cnt<=0, go IDLE; in_valid ignored during READ.
REQ-021 RF read latency is 1 cycle: out_valid is ren issue delayed one register; out_last = delayed (state==READ && cnt==63).
REQ-022 ren_ctrl=0 and raddr_ctrl=0 outside READ.
REQ-023 Back-to-back frames: IDLE reached the cycle after last read issue; next frame's sample 0 may be accepted that cycle while out_valid/out_last of the previous frame is still high.
REQ-024 Write and read never overlap in the same cycle.

Reset
REQ-025 rst_n=0 at a clock edge: state<=IDLE, cnt<=0, out_valid<=0, out_last<=0; resulting outputs in_ready=1, wen_ctrl=0, ren_ctrl=0, addresses=0, busy=0.
REQ-026 Reset mid-WRITE or mid-READ abandons the frame; no partial output after reset.

Configuration
REQ-027 Macro DA_CTRL_BITREV_EN: defined -> s = bit-reversal of 6-bit r (DIF natural-order output); undefined -> s = r (natural pass-through).

Structure
REQ-028 Shared package holds FSM state enum, FRAME_LEN=64, CNT_WIDTH=6, and the bit-reverse function.
REQ-029 No sub-modules; the bit-reverse is a package function.

Verification
REQ-030 Reset: hold rst_n=0 4 cycles -> in_ready=1, wen_ctrl=0, ren_ctrl=0, out_valid=0, busy=0.
REQ-031 Continuous frame, in_valid=1 for 64 cycles, values 0..63 -> sample 9 gives wen_ctrl=8'b0000_0010, waddr_ctrl=1; READ starts cycle 65; with macro out sequence 0,32,16,48,8,...,63, out_last on 64th out_valid.
REQ-032 Gapped input: in_valid toggles every other cycle -> 128 cycles to fill, wen_ctrl=0 on idle cycles, identical output order.
REQ-033 in_valid=1 throughout READ -> in_ready=0, no wen_ctrl pulses for 64 cycles; sample accepted on first IDLE cycle.
REQ-034 Reset asserted at write sample 40 -> IDLE next cycle, next frame writes bank 0 addr 0.
REQ-035 Macro undefined -> ren_ctrl/raddr_ctrl follow natural order, output 0..63.
